// File: rtl/scarf_pat_gen_pkg.sv
// ---------------------------------------------------------------------------
// scarf_pat_gen_pkg
// Shared types and constants for the SCARF pattern-generator sequencer.
//   seqState_t      : sequencer state (IDLE, FETCH, RUN, DONE)
//   GPIO_SEL_*      : num_gpio_sel encodings (1/2/4/8 bits per sample)
//   samplesPerByte  : number of samples unpacked from one RAM byte
// ---------------------------------------------------------------------------
package scarf_pat_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seqState_t;

  localparam logic [1:0] GPIO_SEL_1 = 2'd0;
  localparam logic [1:0] GPIO_SEL_2 = 2'd1;
  localparam logic [1:0] GPIO_SEL_4 = 2'd2;
  localparam logic [1:0] GPIO_SEL_8 = 2'd3;

  // A byte holds 8 >> sel samples, each 1 << sel bits wide.
  function automatic logic [3:0] samplesPerByte(input logic [1:0] sel);
    return 4'd8 >> sel;
  endfunction

endpackage

// File: rtl/scarf_pat_gen_timer.sv
// ---------------------------------------------------------------------------
// scarf_pat_gen_timer
// Two-stage prescaler that produces a one-cycle timestep tick every
// (i_stage1Sel+1)*(i_timestepSel+1) clock cycles.
// Ports:
//   clk            : system clock
//   rst_sync       : synchronous active-high reset
//   i_clear        : holds both counters at zero while asserted
//   i_stage1Sel    : stage-1 wrap value (latched config)
//   i_timestepSel  : stage-2 wrap value (latched config)
//   o_tick         : high on the last cycle of each timestep
// ---------------------------------------------------------------------------
module scarf_pat_gen_timer (
  input  logic       clk,
  input  logic       rst_sync,
  input  logic       i_clear,
  input  logic [3:0] i_stage1Sel,
  input  logic [4:0] i_timestepSel,
  output logic       o_tick
);

  logic [3:0] r_stage1Cnt;
  logic [4:0] r_stage2Cnt;
  logic       w_stage1Wrap;

  assign w_stage1Wrap = (r_stage1Cnt == i_stage1Sel);

  // The tick is combinational so the sample shift happens on the same edge
  // that ends the timestep; both counters start at zero on the first RUN
  // cycle because the sequencer holds i_clear outside of RUN.
  assign o_tick = !i_clear && w_stage1Wrap && (r_stage2Cnt == i_timestepSel);

  // Stage 1 counts clock cycles and wraps at i_stage1Sel; stage 2 only
  // advances on a stage-1 wrap and itself wraps at i_timestepSel.
  always_ff @(posedge clk) begin
    if (rst_sync || i_clear) begin
      r_stage1Cnt <= '0;
      r_stage2Cnt <= '0;
    end else if (w_stage1Wrap) begin
      r_stage1Cnt <= '0;
      if (r_stage2Cnt == i_timestepSel) begin
        r_stage2Cnt <= '0;
      end else begin
        r_stage2Cnt <= r_stage2Cnt + 5'd1;
      end
    end else begin
      r_stage1Cnt <= r_stage1Cnt + 4'd1;
    end
  end

endmodule

// File: rtl/scarf_pat_gen_seq.sv
// ---------------------------------------------------------------------------
// scarf_pat_gen_seq
// Walks pattern RAM from address 0 to end_address, unpacks each byte into
// 1/2/4/8-bit samples (MSB first) and drives one sample per timestep.
// Ports:
//   clk, rst_sync      : clock and synchronous active-high reset
//   enable             : level-sensitive run request
//   repeat_enable      : loop back to address 0 after end_address
//   end_address        : last pattern address, inclusive
//   num_gpio_sel       : bits per sample (0=1, 1=2, 2=4, 3=8)
//   timestep_sel       : stage-2 divide (timestep_sel+1 stage-1 ticks)
//   stage1_count_sel   : stage-1 prescale (stage1_count_sel+1 clocks)
//   ram_rd_en/addr     : RAM read request
//   ram_rd_data        : RAM data, valid one clock after ram_rd_en
//   gpio_out           : current sample, unused upper bits zero
//   active, done       : status (FETCH/RUN and DONE respectively)
// ---------------------------------------------------------------------------
module scarf_pat_gen_seq
  import scarf_pat_gen_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              rst_sync,
  input  logic              enable,
  input  logic              repeat_enable,
  input  logic [ADDR_W-1:0] end_address,
  input  logic [1:0]        num_gpio_sel,
  input  logic [4:0]        timestep_sel,
  input  logic [3:0]        stage1_count_sel,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [GPIO_W-1:0] ram_rd_data,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              active,
  output logic              done
);

  seqState_t         r_state;
  seqState_t         w_stateNext;

  logic              r_repeat;
  logic [ADDR_W-1:0] r_endAddr;
  logic [1:0]        r_gpioSel;
  logic [4:0]        r_timestepSel;
  logic [3:0]        r_stage1Sel;

  logic [GPIO_W-1:0] r_shiftReg;
  logic [GPIO_W-1:0] r_nextByte;
  logic              r_nextValid;
  logic              r_rdPending;
  logic [2:0]        r_sampleIdx;
  logic [ADDR_W-1:0] r_curAddr;

  logic              w_tick;
  logic              w_timerClear;
  logic              w_lastSample;
  logic              w_loadByte;
  logic              w_shiftSample;
  logic              w_bypass;
  logic              w_rdEn;
  logic [ADDR_W-1:0] w_rdAddr;
  logic [ADDR_W-1:0] w_loadAddr;
  logic [3:0]        w_sampleW;
  logic [GPIO_W-1:0] w_sample;

  // Address after a, wrapping to 0 past the last pattern byte. The plain
  // ADDR_W-bit increment also covers end_address = all ones.
  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] lastA);
    return (a == lastA) ? '0 : a + ADDR_W'(1);
  endfunction

  assign w_timerClear = (r_state != RUN);
  assign w_sampleW    = 4'd1 << r_gpioSel;
  assign w_lastSample = ({1'b0, r_sampleIdx} == (samplesPerByte(r_gpioSel) - 4'd1));
  assign w_loadAddr   = nextAddr(r_curAddr, r_endAddr);
  assign w_bypass     = w_loadByte && !r_nextValid;

  scarf_pat_gen_timer u_timer (
    .clk           (clk),
    .rst_sync      (rst_sync),
    .i_clear       (w_timerClear),
    .i_stage1Sel   (r_stage1Sel),
    .i_timestepSel (r_timestepSel),
    .o_tick        (w_tick)
  );

  // Next-state and read-request logic. Reads are issued combinationally so
  // the data arrives in the following cycle: the IDLE read feeds FETCH, and
  // every byte load prefetches the byte after the one being loaded, unless
  // that loaded byte is the final one of a non-repeating pattern.
  always_comb begin
    w_stateNext   = r_state;
    w_rdEn        = 1'b0;
    w_rdAddr      = '0;
    w_loadByte    = 1'b0;
    w_shiftSample = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_stateNext = FETCH;
          w_rdEn      = 1'b1;
        end
      end
      FETCH: begin
        if (!enable) begin
          w_stateNext = IDLE;
        end else begin
          w_stateNext = RUN;
          if (r_repeat || (r_endAddr != '0)) begin
            w_rdEn   = 1'b1;
            w_rdAddr = nextAddr('0, r_endAddr);
          end
        end
      end
      RUN: begin
        if (!enable) begin
          w_stateNext = IDLE;
        end else if (w_tick) begin
          if (!w_lastSample) begin
            w_shiftSample = 1'b1;
          end else if ((r_curAddr == r_endAddr) && !r_repeat) begin
            w_stateNext = DONE;
          end else begin
            w_loadByte = 1'b1;
            if (r_repeat || (w_loadAddr != r_endAddr)) begin
              w_rdEn   = 1'b1;
              w_rdAddr = nextAddr(w_loadAddr, r_endAddr);
            end
          end
        end
      end
      DONE: begin
        if (!enable) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Sample extraction from the top of the shift register. Samples leave
  // MSB first, so the current one always sits in the upper w bits.
  always_comb begin
    w_sample = '0;
    case (r_gpioSel)
      GPIO_SEL_1: w_sample[0]   = r_shiftReg[GPIO_W-1];
      GPIO_SEL_2: w_sample[1:0] = r_shiftReg[GPIO_W-1 -: 2];
      GPIO_SEL_4: w_sample[3:0] = r_shiftReg[GPIO_W-1 -: 4];
      GPIO_SEL_8: w_sample      = r_shiftReg;
      default:    w_sample      = '0;
    endcase
  end

  // Reset state gates the read strobe too, so reset wins over a pending
  // enable in IDLE.
  assign ram_rd_en   = w_rdEn && !rst_sync;
  assign ram_rd_addr = w_rdAddr;
  assign gpio_out    = ((r_state == RUN) || (r_state == DONE)) ? w_sample : '0;
  assign active      = (r_state == FETCH) || (r_state == RUN);
  assign done        = (r_state == DONE);

  // State, latched configuration and the byte pipeline. Returned prefetch
  // data is parked in r_nextByte unless the same cycle consumes it directly
  // (the bypass path that keeps 1-clock, 8-bit patterns bubble free).
  // Leaving for IDLE drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_state       <= IDLE;
      r_repeat      <= 1'b0;
      r_endAddr     <= '0;
      r_gpioSel     <= '0;
      r_timestepSel <= '0;
      r_stage1Sel   <= '0;
      r_shiftReg    <= '0;
      r_nextByte    <= '0;
      r_nextValid   <= 1'b0;
      r_rdPending   <= 1'b0;
      r_sampleIdx   <= '0;
      r_curAddr     <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_rdPending <= w_rdEn;
      if ((r_state == IDLE) && enable) begin
        r_repeat      <= repeat_enable;
        r_endAddr     <= end_address;
        r_gpioSel     <= num_gpio_sel;
        r_timestepSel <= timestep_sel;
        r_stage1Sel   <= stage1_count_sel;
      end
      case (r_state)
        FETCH: begin
          r_shiftReg  <= ram_rd_data;
          r_sampleIdx <= '0;
          r_curAddr   <= '0;
          r_nextValid <= 1'b0;
        end
        RUN: begin
          if (r_rdPending && !w_bypass) begin
            r_nextByte  <= ram_rd_data;
            r_nextValid <= 1'b1;
          end
          if (w_loadByte) begin
            r_shiftReg  <= r_nextValid ? r_nextByte : ram_rd_data;
            r_nextValid <= 1'b0;
            r_sampleIdx <= '0;
            r_curAddr   <= w_loadAddr;
          end else if (w_shiftSample) begin
            r_shiftReg  <= r_shiftReg << w_sampleW;
            r_sampleIdx <= r_sampleIdx + 3'd1;
          end
        end
        default: ;
      endcase
      if (w_stateNext == IDLE) begin
        r_nextValid <= 1'b0;
        r_rdPending <= 1'b0;
        r_sampleIdx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_scarf_pat_gen_seq.sv
// ---------------------------------------------------------------------------
// tb_scarf_pat_gen_seq
// Scoreboard bench for the SCARF pattern sequencer. The stimulus process
// pushes the expected per-cycle outputs computed from a sample-index model;
// a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_scarf_pat_gen_seq;

  typedef struct {
    logic        rep;
    logic [23:0] endA;
    logic [1:0]  gsel;
    logic [4:0]  ts;
    logic [3:0]  s1;
  } cfg_t;

  typedef struct {
    logic [7:0]  gpio;
    logic        act;
    logic        dn;
    logic        chkRd;
    logic        rdEn;
    logic [23:0] rdAddr;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_sync = 1'b1;
  logic        enable = 1'b0;
  logic        repeat_enable = 1'b0;
  logic [23:0] end_address = '0;
  logic [1:0]  num_gpio_sel = '0;
  logic [4:0]  timestep_sel = '0;
  logic [3:0]  stage1_count_sel = '0;
  logic        ram_rd_en;
  logic [23:0] ram_rd_addr;
  logic [7:0]  ram_rd_data = '0;
  logic [7:0]  gpio_out;
  logic        active;
  logic        done;

  logic [7:0]  mem [256];
  exp_t        expQ[$];
  int          compared = 0;
  int          mismatched = 0;

  scarf_pat_gen_seq dut (
    .clk              (clk),
    .rst_sync         (rst_sync),
    .enable           (enable),
    .repeat_enable    (repeat_enable),
    .end_address      (end_address),
    .num_gpio_sel     (num_gpio_sel),
    .timestep_sel     (timestep_sel),
    .stage1_count_sel (stage1_count_sel),
    .ram_rd_en        (ram_rd_en),
    .ram_rd_addr      (ram_rd_addr),
    .ram_rd_data      (ram_rd_data),
    .gpio_out         (gpio_out),
    .active           (active),
    .done             (done)
  );

  always #5 clk = ~clk;

  // RAM model: one-clock read latency; junk on the bus when nothing was read
  // so a stale or misaddressed capture shows up as a wrong sample.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr[7:0]];
    else           ram_rd_data <= 8'($urandom);
  end

  // Expected outputs at cycle k of a run (k=0 is the IDLE cycle with enable
  // high). Derived from the global sample index: each sample lasts P clocks,
  // sample i comes from byte i/spb, bit-group i%spb counted from the MSB.
  function automatic exp_t expectAt(input int k, input cfg_t c);
    exp_t e;
    int w, spb, nS, p, idx, a, s;
    logic dn;
    e.gpio = '0; e.act = 1'b0; e.dn = 1'b0; e.chkRd = 1'b0;
    e.rdEn = 1'b0; e.rdAddr = '0; e.tag = k;
    if (k == 0) begin
      e.chkRd = 1'b1;
      e.rdEn  = 1'b1;
    end else if (k == 1) begin
      e.act = 1'b1;
    end else begin
      w   = 1 << int'(c.gsel);
      spb = 8 / w;
      nS  = (int'(c.endA) + 1) * spb;
      p   = (int'(c.s1) + 1) * (int'(c.ts) + 1);
      idx = (k - 2) / p;
      dn  = 1'b0;
      if (!c.rep && idx >= nS) begin
        idx = nS - 1;
        dn  = 1'b1;
      end else begin
        idx = idx % nS;
      end
      a = idx / spb;
      s = idx % spb;
      e.gpio = 8'((int'(mem[a]) >> (8 - w * (s + 1))) & ((1 << w) - 1));
      e.act  = !dn;
      e.dn   = dn;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int tag,
                             input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, tag, actual, expected);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, compared on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("gpio_out", e.tag, 32'(gpio_out), 32'(e.gpio));
      checkOutput("active", e.tag, 32'(active), 32'(e.act));
      checkOutput("done", e.tag, 32'(done), 32'(e.dn));
      if (e.chkRd) begin
        checkOutput("ram_rd_en", e.tag, 32'(ram_rd_en), 32'(e.rdEn));
        if (e.rdEn) checkOutput("ram_rd_addr", e.tag, 32'(ram_rd_addr), 32'(e.rdAddr));
      end
    end
  end

  function automatic exp_t idleEntry(input int tag);
    exp_t e;
    e.gpio = '0; e.act = 1'b0; e.dn = 1'b0; e.chkRd = 1'b1;
    e.rdEn = 1'b0; e.rdAddr = '0; e.tag = tag;
    return e;
  endfunction

  // One run: raise enable with config c, follow it for nCycles+1 cycles,
  // optionally scramble the config inputs mid-run, then end the run either
  // by dropping enable or by pulsing reset with enable still high.
  task automatic applyStimulus(input cfg_t c, input int nCycles,
                               input bit useReset, input int scrambleAt);
    repeat_enable    = c.rep;
    end_address      = c.endA;
    num_gpio_sel     = c.gsel;
    timestep_sel     = c.ts;
    stage1_count_sel = c.s1;
    enable           = 1'b1;
    for (int k = 0; k <= nCycles + 1; k++) begin
      expQ.push_back(expectAt(k, c));
      if (k == scrambleAt) begin
        repeat_enable    = 1'($urandom);
        end_address      = 24'($urandom);
        num_gpio_sel     = 2'($urandom);
        timestep_sel     = 5'($urandom);
        stage1_count_sel = 4'($urandom);
      end
      if (k == nCycles + 1) begin
        if (useReset) rst_sync = 1'b1;
        else          enable   = 1'b0;
      end
      @(posedge clk); #1;
    end
    expQ.push_back(idleEntry(nCycles + 2));
    @(posedge clk); #1;
    rst_sync = 1'b0;
  endtask

  task automatic randomizeMem();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cfg_t c;
    int   p, full, n;
    bit   useRst;

    randomizeMem();
    @(posedge clk); #1;
    expQ.push_back(idleEntry(-2));
    @(posedge clk); #1;
    expQ.push_back(idleEntry(-1));
    @(posedge clk); #1;
    rst_sync = 1'b0;
    expQ.push_back(idleEntry(0));
    @(posedge clk); #1;

    $display("[TB] directed: A5/3C, 1-bit, 2-clk timestep, no repeat");
    mem[0] = 8'hA5; mem[1] = 8'h3C;
    c = '{rep: 1'b0, endA: 24'd1, gsel: 2'd0, ts: 5'd1, s1: 4'd0};
    applyStimulus(c, 40, 1'b0, -1);

    $display("[TB] directed: A5/3C, 8-bit, 1-clk timestep, repeat");
    c = '{rep: 1'b1, endA: 24'd1, gsel: 2'd3, ts: 5'd0, s1: 4'd0};
    applyStimulus(c, 20, 1'b0, -1);

    $display("[TB] directed: E4, 2-bit, 12-clk timestep");
    mem[0] = 8'hE4;
    c = '{rep: 1'b0, endA: 24'd0, gsel: 2'd1, ts: 5'd2, s1: 4'd3};
    applyStimulus(c, 54, 1'b0, -1);

    $display("[TB] directed: enable drop, config scramble, reset mid-run");
    randomizeMem();
    c = '{rep: 1'b1, endA: 24'd3, gsel: 2'd2, ts: 5'd1, s1: 4'd1};
    applyStimulus(c, 15, 1'b0, -1);
    applyStimulus(c, 30, 1'b0, 5);
    applyStimulus(c, 25, 1'b1, 3);
    c = '{rep: 1'b1, endA: 24'd0, gsel: 2'd3, ts: 5'd0, s1: 4'd0};
    applyStimulus(c, 10, 1'b0, -1);

    $display("[TB] randomized runs");
    for (int it = 0; it < 24; it++) begin
      randomizeMem();
      c.rep  = 1'($urandom_range(0, 1));
      c.endA = 24'($urandom_range(0, 7));
      c.gsel = 2'($urandom_range(0, 3));
      c.s1   = 4'($urandom_range(0, 3));
      c.ts   = 5'($urandom_range(0, 3));
      if (it % 8 == 7) begin
        c.s1 = 4'd15; c.ts = 5'd31; c.endA = 24'd0; c.gsel = 2'd3;
      end
      p    = (int'(c.s1) + 1) * (int'(c.ts) + 1);
      full = 2 + (int'(c.endA) + 1) * (8 >> int'(c.gsel)) * p;
      if (c.rep) n = $urandom_range(3, full + 2 * p);
      else if ($urandom_range(0, 1) == 1) n = full + $urandom_range(1, 4);
      else n = $urandom_range(2, full);
      useRst = ($urandom_range(0, 3) == 0);
      applyStimulus(c, n, useRst, $urandom_range(1, n));
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/scarf_pat_gen_seq.md
Name: scarf_pat_gen_seq

Overview:
Sequencer for the SCARF pattern generator. It takes the pattern-generator configuration from the slave register map (enable, repeat, end address, GPIO width, timestep) and walks pattern RAM from address 0 to end_address. Each RAM byte is unpacked into 1/2/4/8-bit GPIO samples, and one sample is driven per timestep. It sits between the register map, the pattern RAM read port and the GPIO pads.

Parameters:
ADDR_W, 24, pattern RAM address width; matches end_address width.
GPIO_W, 8, gpio_out width; also the RAM data width.

Ports:
clk  input  1  system clock
rst_sync  input  1  synchronous, active-high reset
enable  input  1  from regmap reg0[0]; level-sensitive run request
repeat_enable  input  1  from reg0[1]; loop the pattern at end_address
end_address  input  24  last RAM address of the pattern, inclusive
num_gpio_sel  input  2  0=1 gpio, 1=2, 2=4, 3=8 bits per sample
timestep_sel  input  5  stage-2 divide: timestep_sel+1 stage-1 ticks
stage1_count_sel  input  4  stage-1 prescale: stage1_count_sel+1 clk cycles
ram_rd_en  output  1  RAM read strobe
ram_rd_addr  output  24  RAM read address
ram_rd_data  input  8  RAM data; valid exactly 1 clk after ram_rd_en
gpio_out  output  8  sample; unused upper bits are 0
active  output  1  high in FETCH/RUN
done  output  1  high in DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst_sync); it is sampled only on the clk rising edge.
- Reset values: state=IDLE, all outputs 0, all counters 0, next_valid=0.
- Config latch: all config inputs are captured on the IDLE->FETCH transition and held. Changes while active are ignored.
- Timestep period: (stage1_count_sel+1)*(timestep_sel+1) clk cycles. Range is 1 to 512. The stage-1 counter wraps at stage1_count_sel; the stage-2 counter advances on each stage-1 wrap.
- Samples per byte: 8 >> num_gpio_sel.
  - Samples are taken MSB-first, width w = 1 << num_gpio_sel.
  - The sample drives gpio_out[w-1:0].
- States:
  - IDLE: when enable=1, issue ram_rd_en with ram_rd_addr=0, then go to FETCH.
  - FETCH (1 cycle): load shift_reg from ram_rd_data and drive the first sample on gpio_out. Issue the read for the next address, then go to RUN.
    - Next address is addr+1, or 0 when addr==end_address and repeat_enable=1.
    - No read is issued when addr==end_address and repeat_enable=0.
  - RUN: on each timestep expiry, shift to the next sample.
    - After the last sample of a byte, load shift_reg from next_byte if next_valid=1, otherwise bypass directly from ram_rd_data (needed for 1-cycle timestep with 8 gpio).
    - Each load issues the next prefetch read. Returned data is captured into next_byte and sets next_valid; a load clears next_valid.
  - DONE: entered when the last sample of the byte at end_address expires and repeat=0. gpio_out holds the last sample and done=1.
    - enable=0 -> IDLE.
- Sample timing: the first sample appears on gpio_out the cycle after FETCH. Every sample lasts exactly one timestep, with no gap at byte boundaries or at wrap.
- enable=0 in any state -> IDLE on the next cycle: gpio_out=0, counters cleared, no ram_rd_en, and any in-flight read data is discarded.
- Re-arming after DONE requires enable to be low for at least 1 cycle.
- end_address=0: single-byte pattern. With repeat=1, address 0 is re-read every byte.
- Address arithmetic: ADDR_W bits, no overflow past end_address. end_address=2^24-1 with repeat=1 wraps to 0.
- rst_sync takes priority over enable.

Decomposition:
- Package scarf_pat_gen_pkg: state enum (IDLE, FETCH, RUN, DONE) and num_gpio_sel encoding constants.
- Sub-module scarf_pat_gen_timer: two-stage prescaler producing a 1-cycle timestep_tick. Inputs are the latched stage1_count_sel and timestep_sel, plus a clear.

Test Plan:
- RAM[0..1]=8'hA5,8'h3C; end=1; num_gpio=0; stage1=0; ts=1; repeat=0 -> gpio_out[0] = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, each held 2 clk; then done=1 holding 0.
- Same RAM; num_gpio=3; stage1=0; ts=0; repeat=1 -> gpio_out = A5,3C,A5,3C... changing every clk with no bubble; ram_rd_addr cycles 0,1,0,1.
- num_gpio=1; stage1=3; ts=2; byte 8'hE4 -> gpio_out[1:0] = 3,2,1,0, each held 12 clk.
- enable dropped mid-RUN -> next cycle state IDLE, gpio_out=0, active=0. Re-raising enable restarts at address 0.
- Config inputs changed during RUN -> no effect on sample rate or width until the next start.
- rst_sync asserted mid-RUN with enable=1 -> all outputs 0 on the next edge. After release, the sequence restarts from address 0.
